// File: rtl/led_pwm_fader_pkg.sv
// Shared types and defaults for the LED PWM fader.
// Channel state encoding plus parameter defaults.
package led_pwm_fader_pkg;

    localparam int DEF_CHANNELS = 5;
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_RAMP_DIV = 4;
    localparam int DEF_STEP     = 1;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } ch_state_t;

    function automatic logic is_moving(input ch_state_t s);
        return (s == RISE) || (s == FALL);
    endfunction

endpackage

// File: rtl/led_pwm_fader_channel.sv
// One LED channel: saturating brightness ramp and state.
// Level and state only move on a shared ramp step.
module led_fade_channel
    import led_pwm_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int STEP     = DEF_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                target,
    output logic [PWM_BITS-1:0] level,
    output ch_state_t           state
);

    localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS-1:0] MAX_L  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO_L = '0;

    logic [PWM_BITS:0]   up;
    logic [PWM_BITS:0]   dn;
    logic [PWM_BITS-1:0] nxt_level;
    ch_state_t           nxt_state;
    logic                at_max;
    logic                at_zero;

    // Saturating next level, one bit wider so nothing wraps.
    always_comb begin
        up = {1'b0, level} + STEP_W;
        dn = {1'b0, level} - STEP_W;
        nxt_level = level;
        if (target) begin
            if (up > MAX_W)
                nxt_level = MAX_L;
            else
                nxt_level = up[PWM_BITS-1:0];
        end else begin
            // Borrow out of the wide subtract means we hit bottom.
            if (dn[PWM_BITS])
                nxt_level = ZERO_L;
            else
                nxt_level = dn[PWM_BITS-1:0];
        end
        at_max  = (nxt_level == MAX_L);
        at_zero = (nxt_level == ZERO_L);
    end

    // Next state from current state, target and the new level.
    always_comb begin
        nxt_state = state;
        unique case (state)
            OFF: begin
                if (target)
                    nxt_state = at_max ? ON : RISE;
            end
            RISE: begin
                if (!target)
                    nxt_state = at_zero ? OFF : FALL;
                else if (at_max)
                    nxt_state = ON;
            end
            ON: begin
                if (!target)
                    nxt_state = at_zero ? OFF : FALL;
            end
            FALL: begin
                if (target)
                    nxt_state = at_max ? ON : RISE;
                else if (at_zero)
                    nxt_state = OFF;
            end
        endcase
    end

    // Commit level and state on each ramp step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            state <= OFF;
        end else if (step) begin
            level <= nxt_level;
            state <= nxt_state;
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM fader top.
// Shared PWM counter and ramp prescaler drive per-channel faders.
module led_pwm_fader
    import led_pwm_fader_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int RAMP_DIV = DEF_RAMP_DIV,
    parameter int STEP     = DEF_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] pattern,
    output logic [CHANNELS-1:0] led,
    output logic                ramp_tick,
    output logic                busy
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]       PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX_L    = {PWM_BITS{1'b1}};

    logic [CHANNELS-1:0] target_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PW-1:0]       prescaler;
    logic                period_end;
    logic                ramp_step;

    logic [PWM_BITS-1:0] level [CHANNELS];
    ch_state_t           state [CHANNELS];

    logic [CHANNELS-1:0] led_nxt;
    logic                moving;

    assign period_end = (pwm_cnt == MAX_L) & enable;
    assign ramp_step  = period_end & (prescaler == PRE_LAST);

    // Resynchronise the pattern; all decisions use this copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            target_q <= '0;
        else
            target_q <= pattern;
    end

    // Free-running PWM counter, frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pwm_cnt <= '0;
        else if (enable)
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Count PWM periods; wrap marks a ramp step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prescaler <= '0;
        else if (period_end) begin
            if (prescaler == PRE_LAST)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .step   (ramp_step),
            .target (target_q[i]),
            .level  (level[i]),
            .state  (state[i])
        );
    end

    // PWM compare per channel and any-channel-moving flag.
    always_comb begin
        led_nxt = '0;
        moving  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            led_nxt[i] = enable & (level[i] > pwm_cnt);
            moving     = moving | is_moving(state[i]);
        end
    end

    // Register all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led       <= '0;
            ramp_tick <= 1'b0;
            busy      <= 1'b0;
        end else begin
            led       <= led_nxt;
            ramp_tick <= ramp_step;
            busy      <= moving;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader.
// Levels are inferred from led duty over a full PWM period.
module tb_led_pwm_fader;

    localparam int CH = 5;
    localparam int PB = 4;
    localparam int RD = 2;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CH-1:0] pattern;
    logic [CH-1:0] led;
    logic          ramp_tick;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    int dcnt [CH];
    int n;
    int fall_exp [4] = '{11, 7, 3, 0};

    always #5 clk = ~clk;

    led_pwm_fader #(
        .CHANNELS (CH),
        .PWM_BITS (PB),
        .RAMP_DIV (RD),
        .STEP     (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pattern   (pattern),
        .led       (led),
        .ramp_tick (ramp_tick),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ramp_tick !== 1'b1 && cyc < 200);
        chk("tick_seen", ramp_tick, 1);
    endtask

    task automatic duty();
        for (int i = 0; i < CH; i++) dcnt[i] = 0;
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) dcnt[i] += int'(led[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        pattern = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            pattern = CH'(k);
            @(negedge clk);
            chk("rst_hold", {led, busy, ramp_tick}, 0);
        end
        pattern = '0;
        @(negedge clk);
        rst = 1'b0;
        duty();
        chk("idle_duty", dcnt[0] + dcnt[1] + dcnt[2] + dcnt[3] + dcnt[4], 0);
        chk("idle_busy", busy, 0);

        pattern = 5'b00001;
        wait_tick(n);
        duty();
        chk("rise_l4", dcnt[0], 4);
        chk("rise_busy", busy, 1);
        chk("rise_others", dcnt[1] + dcnt[2] + dcnt[3] + dcnt[4], 0);
        wait_tick(n);
        chk("tick_period", n, 16);
        @(negedge clk);
        chk("tick_width", ramp_tick, 0);
        duty();
        chk("rise_l8", dcnt[0], 8);
        wait_tick(n);
        chk("tick_period2", n, 15);
        duty();
        chk("rise_l12", dcnt[0], 12);
        chk("rise_busy12", busy, 1);
        wait_tick(n);
        duty();
        chk("rise_l15", dcnt[0], 15);
        chk("on_busy", busy, 0);
        wait_tick(n);
        duty();
        chk("on_hold", dcnt[0], 15);

        pattern = '0;
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            duty();
            chk("fall_lvl", dcnt[0], fall_exp[k]);
        end
        chk("off_busy", busy, 0);

        pattern = 5'b00001;
        wait_tick(n);
        duty();
        chk("rev_l4", dcnt[0], 4);
        wait_tick(n);
        duty();
        chk("rev_l8", dcnt[0], 8);
        pattern = '0;
        wait_tick(n);
        duty();
        chk("rev_down4", dcnt[0], 4);
        chk("rev_busy", busy, 1);
        wait_tick(n);
        duty();
        chk("rev_down0", dcnt[0], 0);
        chk("rev_idle", busy, 0);

        pattern = 5'b00001;
        repeat (3) @(negedge clk);
        pattern = '0;
        wait_tick(n);
        duty();
        chk("glitch_lvl", dcnt[0], 0);
        chk("glitch_busy", busy, 0);

        pattern = 5'b00001;
        wait_tick(n);
        duty();
        chk("pre_pause_l4", dcnt[0], 4);
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("frozen_led", led, 0);
        end
        enable = 1'b1;
        wait_tick(n);
        chk("pause_period", n + 26, 42);
        duty();
        chk("post_pause_l8", dcnt[0], 8);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led[0] !== 1'b1 && n < 20);
        chk("led_before_rst", led[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("async_led", led, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst     = 1'b0;
        pattern = 5'b10101;
        wait_tick(n);
        duty();
        chk("restart_ch0", dcnt[0], 4);
        chk("restart_ch2", dcnt[2], 4);
        chk("restart_ch4", dcnt[4], 4);
        chk("restart_off", dcnt[1] + dcnt[3], 0);
        wait_tick(n);
        duty();
        chk("half_ch0", dcnt[0], 8);
        chk("half_ch4", dcnt[4], 8);

        pattern = 5'b00100;
        wait_tick(n);
        duty();
        chk("mix_ch0", dcnt[0], 4);
        chk("mix_ch2", dcnt[2], 12);
        chk("mix_ch4", dcnt[4], 4);
        chk("mix_busy", busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 Parameter CHANNELS, default 5, number of LED channels.
REQ-002 Parameter PWM_BITS, default 8, PWM counter and brightness level width; MAX = 2^PWM_BITS-1.
REQ-003 Parameter RAMP_DIV, default 4, PWM periods per ramp step (>=1).
REQ-004 Parameter STEP, default 1, level change per ramp step (1..MAX).
REQ-005 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high = run; low = freeze and blank outputs.
REQ-008 pattern  input  CHANNELS  per-channel on/off target, same clock domain (e.g. a Gray-coded LED counter output).
REQ-009 led  output  CHANNELS  registered PWM drive, one bit per channel.
REQ-010 ramp_tick  output  1  registered one-cycle pulse marking each ramp step.
REQ-011 busy  output  1  registered; high while any channel is in RISE or FALL.

Function
REQ-012 pattern SHALL be registered into target_q every cycle; all decisions SHALL use target_q.
REQ-013 pwm_cnt (PWM_BITS wide) SHALL increment by 1 each enabled cycle, wrapping MAX->0; period_end = (pwm_cnt == MAX) & enable.
REQ-014 The prescaler SHALL count period_end events 0..RAMP_DIV-1; ramp step occurs on a period_end with prescaler == RAMP_DIV-1, which resets the prescaler to 0.
REQ-015 ramp_tick SHALL be high for exactly the cycle after each ramp step.
REQ-016 Per channel, level SHALL be updated only on a ramp step: target 1 -> min(level+STEP, MAX); target 0 -> max(level-STEP, 0); arithmetic SHALL be one bit wider than level, with no wrap-around.
REQ-017 Per-channel state SHALL be one of OFF (level 0), RISE, ON (level MAX), FALL.
REQ-018 Transitions SHALL be evaluated on each ramp step: OFF->RISE if target 1; ON->FALL if target 0; RISE->ON when new level == MAX; FALL->OFF when new level == 0; RISE<->FALL immediately on target reversal, continuing from the current level.
REQ-019 A target change between ramp steps SHALL take effect at the next ramp step; target pulses shorter than one ramp interval that revert before the step SHALL have no effect.
REQ-020 led[i] SHALL be registered as enable & (level[i] > pwm_cnt), giving duty level/2^PWM_BITS (MAX -> (2^PWM_BITS-1)/2^PWM_BITS; 0 -> always off).
REQ-021 led latency from level or pwm_cnt change SHALL be one cycle.
REQ-022 enable low SHALL hold pwm_cnt, prescaler, levels and states, and SHALL drive led to 0 on the next edge; operation SHALL resume from the held values when enable returns high.
REQ-023 busy SHALL be the registered OR of (state in RISE or FALL) across channels.

Reset
REQ-024 rst high SHALL immediately force led=0, ramp_tick=0, busy=0, pwm_cnt=0, prescaler=0, target_q=0, and every level to 0 with state OFF, independent of clk.
REQ-025 Reset asserted mid-ramp SHALL discard the ramp; after release every channel SHALL restart from OFF and follow pattern.

Structure
REQ-026 A shared package SHALL hold the channel-state enum (OFF, RISE, ON, FALL) and the default values of PWM_BITS, RAMP_DIV and STEP.
REQ-027 Per-channel level/state logic SHALL be a sub-module led_fade_channel, instantiated CHANNELS times; pwm_cnt and the prescaler SHALL be shared in the top.

Verification (PWM_BITS=4, RAMP_DIV=2, STEP=4, CHANNELS=5)
REQ-028 Hold rst high, toggle pattern -> led=0, busy=0, ramp_tick=0 throughout; after release all levels are 0.
REQ-029 pattern=5'b00001 held -> level[0] takes 4, 8, 12, 15 on successive ramp steps (every 32 cycles); busy falls after 15 is reached; led[0] is then high 15 of every 16 cycles.
REQ-030 Set pattern[0], clear it after level reaches 8 -> next steps give 4 then 0; state returns to OFF; busy drops.
REQ-031 enable low for 10 cycles mid-ramp -> led=0 from the next cycle; afterwards the level sequence is identical to the uninterrupted run, shifted by 10 cycles.
REQ-032 Assert rst asynchronously mid-ramp with level 8 -> led=0 before the next clk edge; level is 0 after release.
REQ-033 Force level 8 (pattern held until level 8, then enable frozen-free hold via pattern toggle) -> led high exactly 8 of 16 cycles per PWM period.
